demux_stream_1ton: RTL
======================

// Module: demux_stream_1toN
// PURPOSE
//   Registered 1-to-N stream demultiplexer with valid/ready handshake and packet-locked select.
//   Routes each input beat to one of N=2**SEL_W output channels. Holds the channel fixed from the
//   first beat of a packet to its last beat. Keeps a saturating per-channel packet counter.
//   Sits between a shared producer bus and N per-channel consumers; next generation of the 1-to-4 demux.
// PARAMETERS
//   WIDTH  8  data width per beat
//   SEL_W  3  select width; channel count N = 2**SEL_W
//   CNT_W  8  width of each per-channel packet counter
// PORTS
//   clk        in   1          rising-edge clock
//   rst        in   1          synchronous reset, active-high
//   en_n       in   1          enable, active-low; 1 = stop accepting input
//   sel        in   SEL_W      channel select, sampled on first beat of a packet only
//   in_data    in   WIDTH      input beat data
//   in_valid   in   1          input beat valid
//   in_last    in   1          input beat is last of packet
//   in_ready   out  1          block accepts beat this cycle
//   out_data   out  WIDTH      registered data, shared by all channels
//   out_last   out  1          registered last flag
//   out_valid  out  N          one-hot valid, bit k = beat for channel k
//   out_ready  in   N          per-channel ready; only the bit of the held channel is used
//   cnt_clr    in   1          clear all packet counters
//   cnt_ch     in   SEL_W      counter read index
//   cnt_val    out  CNT_W      packet count of channel cnt_ch, combinational read
// BEHAVIOUR
//   Reset, synchronous:
//     - out_valid=0, out_data=0, out_last=0, all counters=0, state=IDLE.
//     - Any held beat is discarded; an open packet is abandoned.
//   Output stage:
//     - Single holding register: hold_v, hold_ch, data, last. out_valid = hold_v ? onehot(hold_ch) : 0.
//   Ready rule:
//     - in_ready = !rst & !en_n & (!hold_v | out_ready[hold_ch]).
//     - Accept = in_valid & in_ready.
//   Timing:
//     - Latency is 1 cycle from accept to out_valid.
//     - Output handshake and a new accept in the same cycle reload the register: 1 beat/cycle sustained.
//   Output handshake without a new accept clears hold_v.
//   Target channel: tgt = (state==IDLE) ? sel : lock_ch.
//   FSM:
//     - IDLE: accept with in_last=0 -> lock_ch<=sel, go PKT. Accept with in_last=1 -> single-beat
//       packet, stay IDLE.
//     - PKT: sel ignored; every accept goes to lock_ch. Accept with in_last=1 -> go IDLE.
//   Enable:
//     - en_n=1 blocks new accepts only. The held beat still drains. State and lock_ch are retained,
//       so a packet resumes on the same channel when en_n returns to 0.
//   Valid/data ordering:
//     - in_valid may be asserted without in_ready; the producer holds data until accept.
//     - out_data and out_last stay stable while out_valid is set and out_ready is low.
//   Counters:
//     - Counter k increments when out_valid[k] & out_ready[k] & out_last.
//     - Counters saturate at 2**CNT_W-1; no wrap.
//     - cnt_clr sets all counters to 0 and wins over a same-cycle increment.
//   Unselected out_ready bits are ignored. sel changes mid-packet have no effect.
// TESTING
//   - Reset, then en_n=0, sel=5, one beat in_data=8'hA5, in_last=1, out_ready=all 1:
//     next cycle out_valid=8'b0010_0000, out_data=A5, out_last=1; cnt_ch=5 -> cnt_val=1.
//   - 3-beat packet with sel=2 on beat 0, sel=6 on beats 1-2:
//     all beats appear on out_valid[2]; FSM back in IDLE after beat 2.
//   - Hold out_ready[3]=0 for 4 cycles with beat pending for ch3:
//     in_ready=0, out_data stable. Release: beat completes, then back-to-back beats at 1/cycle.
//   - en_n=1 mid-packet (ch4) for 3 cycles:
//     held beat drains, no accepts. en_n=0: remaining beats go to ch4 even if sel=1.
//   - 256 single-beat packets to ch0, CNT_W=8:
//     cnt_val saturates at 255. cnt_clr asserted with a same-cycle last handshake -> cnt_val=0.
//   - rst asserted while hold_v=1 mid-packet:
//     next cycle out_valid=0, counters=0. Next first beat uses current sel.

Source files
------------

// File: rtl/demux_stream_1ton_if.sv
// demux_stream_1ton_if: stream bus between a shared producer, the demux and N per-channel consumers.
// Input side: sel / in_data / in_valid / in_last / in_ready. Output side: out_data / out_last are
// shared by all channels, and out_valid / out_ready carry one bit per channel (N = 2**SEL_W).
// Modports: master = producer plus consumers (drives inputs and out_ready); slave = the demux.
interface demux_stream_1ton_if #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
);
  localparam int N = 1 << SEL_W;

  logic [SEL_W-1:0] sel;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;

  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic [N-1:0]     out_valid;
  logic [N-1:0]     out_ready;

  modport master (
    output sel, in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_last, out_valid
  );

  modport slave (
    input  sel, in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_last, out_valid
  );
endinterface

// File: rtl/demux_stream_1ton.sv
// demux_stream_1ton: registered 1-to-N stream demux; the channel is locked from first to last beat of a packet.
// Latency: 1 cycle from accept to out_valid; sustains 1 beat/cycle when the held channel is ready.
// Backpressure: in_ready drops while the held beat's channel is not ready, during rst, or while en_n=1.
// Ports: clk; rst (synchronous, active-high); en_n (active-low enable, blocks new accepts only);
//        bus (stream interface, slave side); cnt_clr / cnt_ch / cnt_val (saturating per-channel
//        packet counters, cnt_val is a combinational read of counter cnt_ch).
module demux_stream_1ton #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_n,
  demux_stream_1ton_if.slave bus,
  input  logic               cnt_clr,
  input  logic [SEL_W-1:0]   cnt_ch,
  output logic [CNT_W-1:0]   cnt_val
);
  localparam int N = 1 << SEL_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {IDLE, PKT} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  state_t           state;
  state_t           state_nxt;
  logic [SEL_W-1:0] lock_ch;
  logic [SEL_W-1:0] lock_nxt;
  logic [SEL_W-1:0] tgt;

  // Single holding register feeding every output channel.
  logic             hold_v;
  logic [SEL_W-1:0] hold_ch;
  beat_t            hold;

  logic             accept;
  logic             out_hs;
  logic [CNT_W-1:0] cnt [N];

  // Only the ready bit of the channel that owns the held beat matters.
  assign out_hs       = hold_v && bus.out_ready[hold_ch];
  assign bus.in_ready = !rst && !en_n && (!hold_v || bus.out_ready[hold_ch]);
  assign accept       = bus.in_valid && bus.in_ready;

  // sel is only honoured on the first beat of a packet.
  assign tgt = (state == IDLE) ? bus.sel : lock_ch;

  always_comb begin
    state_nxt = state;
    lock_nxt  = lock_ch;
    case (state)
      IDLE: begin
        // A single-beat packet never leaves IDLE.
        if (accept && !bus.in_last) begin
          state_nxt = PKT;
          lock_nxt  = bus.sel;
        end
      end
      PKT: begin
        if (accept && bus.in_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and lock_ch only move on accept, so they survive en_n=1 and a packet resumes in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lock_ch <= '0;
    end else begin
      state   <= state_nxt;
      lock_ch <= lock_nxt;
    end
  end

  // A new accept reloads the register even when the old beat leaves in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v  <= 1'b0;
      hold_ch <= '0;
      hold    <= '0;
    end else if (accept) begin
      hold_v    <= 1'b1;
      hold_ch   <= tgt;
      hold.data <= bus.in_data;
      hold.last <= bus.in_last;
    end else if (out_hs) begin
      hold_v <= 1'b0;
    end
  end

  assign bus.out_data  = hold.data;
  assign bus.out_last  = hold.last;
  assign bus.out_valid = hold_v ? (N'(1) << hold_ch) : '0;

  // A packet is counted when its last beat is handed off; clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (rst || cnt_clr) begin
        cnt[k] <= '0;
      end else if (out_hs && hold.last && (hold_ch == SEL_W'(k)) && (cnt[k] != CNT_MAX)) begin
        cnt[k] <= cnt[k] + 1'b1;
      end
    end
  end

  assign cnt_val = cnt[cnt_ch];
endmodule
